// File: rtl/mem_ctrl_pkg.sv
// Shared widths and types for the memory arbiter and the clients that talk to it.
package mem_ctrl_pkg;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 4;    // strobe down-counter, covers 1..15 cycles

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner: on a tie the port that was not served last wins.
module rr_arb2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last,
    output logic [1:0] o_gnt_c
);

    always_comb begin
        o_gnt_c = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_gnt_c = i_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt_c = {i_valid1, i_valid0};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter that sequences single-word accesses to the asynchronous
// 64x64 memory through a setup / strobe / hold cycle.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          MemRd,
    output logic          MemWr,
    output logic [AW-1:0] Addr,
    inout  wire  [DW-1:0] DataBus
);

    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    req_t          r_req;
    req_t          w_req_nxt;
    logic          r_port;
    logic          w_port_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic [1:0]    w_gnt;
    logic          w_accept;
    logic          r_memrd;
    logic          r_memwr;
    logic          r_drive_en;
    logic          w_memrd_nxt;
    logic          w_memwr_nxt;
    logic          w_drive_en_nxt;
    logic [1:0]    r_rsp_valid;
    logic [1:0]    w_rsp_valid_nxt;
    logic          w_sample;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    rr_arb2 u_arb (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_last   (r_last),
        .o_gnt_c  (w_gnt)
    );

    assign w_accept   = (r_state == IDLE) && (w_gnt != 2'b00);
    assign req0_ready = rst_n && (r_state == IDLE) && w_gnt[0];
    assign req1_ready = rst_n && (r_state == IDLE) && w_gnt[1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request-latch logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_port_nxt  = r_port;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                    w_port_nxt  = w_gnt[1];
                    w_last_nxt  = w_gnt[1];
                    if (w_gnt[1]) begin
                        w_req_nxt.we    = req1_we;
                        w_req_nxt.addr  = req1_addr;
                        w_req_nxt.wdata = req1_wdata;
                    end else begin
                        w_req_nxt.we    = req0_we;
                        w_req_nxt.addr  = req0_addr;
                        w_req_nxt.wdata = req0_wdata;
                    end
                end
            end
            SETUP: begin
                w_state_nxt = STROBE;
                w_cnt_nxt   = STROBE_LOAD;
            end
            STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            HOLD: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode, one cycle ahead so every memory pin comes straight from a flop
    always_comb begin
        w_memrd_nxt     = 1'b0;
        w_memwr_nxt     = 1'b0;
        w_drive_en_nxt  = 1'b0;
        w_rsp_valid_nxt = 2'b00;
        w_sample        = 1'b0;
        if (w_state_nxt == STROBE) begin
            w_memrd_nxt = !w_req_nxt.we;
            w_memwr_nxt = w_req_nxt.we;
        end
        if (w_state_nxt != IDLE) begin
            w_drive_en_nxt = w_req_nxt.we;
        end
        if (w_state_nxt == HOLD) begin
            w_rsp_valid_nxt = r_port ? 2'b10 : 2'b01;
        end
        if ((r_state == STROBE) && (r_cnt == '0)) begin
            w_sample = !r_req.we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_req       <= '0;
            r_port      <= 1'b0;
            r_last      <= 1'b1;
            r_memrd     <= 1'b0;
            r_memwr     <= 1'b0;
            r_drive_en  <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_req       <= w_req_nxt;
            r_port      <= w_port_nxt;
            r_last      <= w_last_nxt;
            r_memrd     <= w_memrd_nxt;
            r_memwr     <= w_memwr_nxt;
            r_drive_en  <= w_drive_en_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            if (w_sample && r_port) begin
                r_rdata1 <= DataBus;
            end
            if (w_sample && !r_port) begin
                r_rdata0 <= DataBus;
            end
        end
    end

    assign MemRd      = r_memrd;
    assign MemWr      = r_memwr;
    assign Addr       = r_req.addr;
    assign DataBus    = r_drive_en ? r_req.wdata : {DW{1'bz}};
    assign rsp0_valid = r_rsp_valid[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp0_rdata = r_rdata0;
    assign rsp1_rdata = r_rdata1;

endmodule
